// File: rtl/baby_kyber_decrypt_if.sv
// rtl/baby_kyber_decrypt_if.sv - ciphertext/key input and decoded-message output bundle
interface baby_kyber_decrypt_if;
  localparam int N = 4;
  localparam int K = 2;
  localparam int W = 32;

  logic                          in_valid;
  logic                          in_ready;
  logic [K-1:0][N-1:0][W-1:0]    sk;
  logic [K-1:0][N-1:0][W-1:0]    u;
  logic [N-1:0][W-1:0]           v;
  logic                          abort;
  logic                          out_valid;
  logic                          out_ready;
  logic [N-1:0]                  msg;
  logic [N-1:0][W-1:0]           w;
  logic                          busy;

  modport master (
    output in_valid, sk, u, v, abort, out_ready,
    input  in_ready, out_valid, msg, w, busy
  );

  modport slave (
    input  in_valid, sk, u, v, abort, out_ready,
    output in_ready, out_valid, msg, w, busy
  );
endinterface

// File: rtl/baby_kyber_decrypt.sv
// rtl/baby_kyber_decrypt.sv - Baby-Kyber decryption: w = v - s.u in Z_17[x]/(x^4+1), one MAC per cycle
module baby_kyber_decrypt (
  input  logic                  clk,
  input  logic                  rst_n,
  baby_kyber_decrypt_if.slave   bus
);
  localparam int Q = 17;
  localparam int N = 4;
  localparam int K = 2;
  localparam int W = 32;

  typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [4:0]                 r_cnt;
  logic [K-1:0][N-1:0][4:0]   r_s;
  logic [K-1:0][N-1:0][4:0]   r_u;
  logic [N-1:0][4:0]          r_v;
  logic signed [W-1:0]        r_acc [N];
  logic [N-1:0][4:0]          r_w;
  logic [N-1:0]               r_msg;

  logic                       w_accept;
  logic                       w_k;
  logic [1:0]                 w_i;
  logic [1:0]                 w_j;
  logic [2:0]                 w_sum;
  logic signed [W-1:0]        w_prod;
  logic signed [W-1:0]        w_diff [N];
  logic [4:0]                 w_red [N];

  // Truncating % leaves a negative remainder for negative x; fold it back into [0,Q-1].
  function automatic logic [4:0] mod_q(input logic signed [W-1:0] x);
    logic signed [W-1:0] r;
    r = x % Q;
    if (r < 0) r = r + Q;
    return r[4:0];
  endfunction

  assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.abort;
  assign w_k      = r_cnt[4];
  assign w_i      = r_cnt[3:2];
  assign w_j      = r_cnt[1:0];
  assign w_sum    = {1'b0, w_i} + {1'b0, w_j};
  assign w_prod   = signed'(W'(r_s[w_k][w_i]) * W'(r_u[w_k][w_j]));

  always_comb begin
    for (int n = 0; n < N; n++) begin
      w_diff[n] = signed'(W'(r_v[n])) - r_acc[n];
      w_red[n]  = mod_q(w_diff[n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_state_nxt = MAC;
      MAC:     if (r_cnt == 5'd31) w_state_nxt = FINAL;
      FINAL:   w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_s   <= '0;
      r_u   <= '0;
      r_v   <= '0;
      r_w   <= '0;
      r_msg <= '0;
      for (int n = 0; n < N; n++) r_acc[n] <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      for (int n = 0; n < N; n++) begin
        r_acc[n] <= '0;
        r_v[n]   <= mod_q(bus.v[n]);
        for (int k = 0; k < K; k++) begin
          r_s[k][n] <= mod_q(bus.sk[k][n]);
          r_u[k][n] <= mod_q(bus.u[k][n]);
        end
      end
    end else if (!bus.abort) begin
      if (r_state == MAC) begin
        r_cnt <= r_cnt + 5'd1;
        // x^N = -1: terms landing at or beyond degree N wrap with negated sign.
        if (w_sum[2]) r_acc[w_sum[1:0]] <= r_acc[w_sum[1:0]] - w_prod;
        else          r_acc[w_sum[1:0]] <= r_acc[w_sum[1:0]] + w_prod;
      end else if (r_state == FINAL) begin
        for (int n = 0; n < N; n++) begin
          r_w[n]   <= w_red[n];
          r_msg[n] <= (w_red[n] >= 5'd5) && (w_red[n] <= 5'd12);
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == MAC) || (r_state == FINAL);
  assign bus.msg       = r_msg;

  always_comb begin
    bus.w = '0;
    for (int n = 0; n < N; n++) bus.w[n] = W'(r_w[n]);
  end
endmodule

// File: tb/tb_baby_kyber_decrypt.sv
// tb/tb_baby_kyber_decrypt.sv - directed-vector bench for baby_kyber_decrypt
module tb_baby_kyber_decrypt;
  typedef logic [1:0][3:0][31:0] vec_t;
  typedef logic [3:0][31:0]      poly_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  baby_kyber_decrypt_if bus();

  baby_kyber_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Caller sits on a falling edge; the next rising edge is the accepting edge.
  task automatic start_op(input vec_t sk, input vec_t u, input poly_t v);
    bus.sk = sk;
    bus.u = u;
    bus.v = v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.msg !== 4'b0) begin bad++; $display("FAIL reset_msg got=%b exp=0000", bus.msg); end
    total++; if (bus.w !== '0) begin bad++; $display("FAIL reset_w got=%h exp=0", bus.w); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_decode();
    vec_t sk = '0, u = '0;
    poly_t v, ew;
    int lat;
    v[0] = 13; v[1] = 5; v[2] = 12; v[3] = 4;
    ew = v;
    start_op(sk, u, v);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL decode_busy got=%b exp=1", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL decode_in_ready got=%b exp=0", bus.in_ready); end
    wait_done(lat);
    total++; if (lat !== 33) begin bad++; $display("FAIL decode_latency got=%0d exp=33", lat); end
    total++; if (bus.w !== ew) begin bad++; $display("FAIL decode_w got=%h exp=%h", bus.w, ew); end
    total++; if (bus.msg !== 4'b0110) begin bad++; $display("FAIL decode_msg got=%b exp=0110", bus.msg); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL decode_busy_done got=%b exp=0", bus.busy); end
    release_result();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL decode_release got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_wrap();
    vec_t sk = '0, u = '0;
    poly_t v, ew;
    int lat;
    sk[0][1] = 1;
    u[0][0] = 1; u[0][1] = 2; u[0][2] = 3; u[0][3] = 4;
    v[0] = 13; v[1] = 9; v[2] = 9; v[3] = 9;
    ew[0] = 0; ew[1] = 8; ew[2] = 7; ew[3] = 6;
    start_op(sk, u, v);
    wait_done(lat);
    total++; if (lat !== 33) begin bad++; $display("FAIL wrap_latency got=%0d exp=33", lat); end
    total++; if (bus.w !== ew) begin bad++; $display("FAIL wrap_w got=%h exp=%h", bus.w, ew); end
    total++; if (bus.msg !== 4'b1110) begin bad++; $display("FAIL wrap_msg got=%b exp=1110", bus.msg); end
    release_result();
  endtask

  task automatic test_negative();
    vec_t sk = '0, u = '0;
    poly_t v = '0, ew = '0;
    int lat;
    sk[0][0] = -32'sd1;
    u[0][0] = 3;
    v[0] = 6;
    ew[0] = 9;
    start_op(sk, u, v);
    wait_done(lat);
    total++; if (bus.w !== ew) begin bad++; $display("FAIL neg_w got=%h exp=%h", bus.w, ew); end
    total++; if (bus.msg !== 4'b0001) begin bad++; $display("FAIL neg_msg got=%b exp=0001", bus.msg); end
    release_result();
  endtask

  task automatic test_back_to_back();
    vec_t sk = '0, u = '0, sk3 = '0, u3 = '0;
    poly_t v, ew, v3 = '0, ew3 = '0;
    int lat;
    sk[0][1] = 1;
    u[0][0] = 1; u[0][1] = 2; u[0][2] = 3; u[0][3] = 4;
    v[0] = 13; v[1] = 9; v[2] = 9; v[3] = 9;
    ew[0] = 0; ew[1] = 8; ew[2] = 7; ew[3] = 6;
    sk3[0][0] = -32'sd1; u3[0][0] = 3; v3[0] = 6; ew3[0] = 9;
    start_op(sk, u, v);
    wait_done(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      total++; if (bus.w !== ew) begin bad++; $display("FAIL hold_w cyc=%0d got=%h exp=%h", c, bus.w, ew); end
      total++; if (bus.msg !== 4'b1110) begin bad++; $display("FAIL hold_msg cyc=%0d got=%b exp=1110", c, bus.msg); end
    end
    release_result();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_out_valid got=%b exp=0", bus.out_valid); end
    start_op(sk3, u3, v3);
    wait_done(lat);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    total++; if (bus.w !== ew3) begin bad++; $display("FAIL b2b_w got=%h exp=%h", bus.w, ew3); end
    total++; if (bus.msg !== 4'b0001) begin bad++; $display("FAIL b2b_msg got=%b exp=0001", bus.msg); end
    release_result();
  endtask

  task automatic test_reset_mid();
    vec_t sk = '0, u = '0;
    poly_t v;
    int lat;
    sk[0][1] = 1;
    u[0][0] = 1; u[0][1] = 2; u[0][2] = 3; u[0][3] = 4;
    v[0] = 13; v[1] = 9; v[2] = 9; v[3] = 9;
    start_op(sk, u, v);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.msg !== 4'b0) begin bad++; $display("FAIL rstmid_msg got=%b exp=0000", bus.msg); end
    total++; if (bus.w !== '0) begin bad++; $display("FAIL rstmid_w got=%h exp=0", bus.w); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    start_op(sk, u, v);
    wait_done(lat);
    total++; if (lat !== 33) begin bad++; $display("FAIL rerun_latency got=%0d exp=33", lat); end
    total++; if (bus.msg !== 4'b1110) begin bad++; $display("FAIL rerun_msg got=%b exp=1110", bus.msg); end
    release_result();
  endtask

  task automatic test_abort();
    vec_t sk = '0, u = '0;
    poly_t v, ew_prev;
    int seen = 0;
    v[0] = 13; v[1] = 5; v[2] = 12; v[3] = 4;
    ew_prev[0] = 0; ew_prev[1] = 8; ew_prev[2] = 7; ew_prev[3] = 6;
    start_op(sk, u, v);
    repeat (19) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_out_valid_seen got=%0d exp=0", seen); end
    total++; if (bus.w !== ew_prev) begin bad++; $display("FAIL abort_w_kept got=%h exp=%h", bus.w, ew_prev); end
    total++; if (bus.msg !== 4'b1110) begin bad++; $display("FAIL abort_msg_kept got=%b exp=1110", bus.msg); end
    bus.in_valid = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_idle_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    bus.sk = '0;
    bus.u = '0;
    bus.v = '0;
    test_reset();
    test_decode();
    test_wrap();
    test_negative();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
